// File: rtl/apply_ctrl.sv
// Apply-phase sequencer: walks vertex IDs 0..n-1 one at a time through
// read -> comp -> optional writeback, then reports update count and convergence.
module apply_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int VID_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VID_WIDTH-1:0]  num_vertices,
    output logic                  busy,
    output logic                  done,
    output logic [VID_WIDTH-1:0]  update_count,
    output logic                  converged,
    output logic                  rd_valid_o,
    output logic [VID_WIDTH-1:0]  rd_vid_o,
    input  logic                  rd_ready_i,
    input  logic                  rd_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] rd_dst_i,
    input  logic [DATA_WIDTH-1:0] rd_tmp_i,
    output logic                  rd_rsp_ready_o,
    output logic                  comp_valid_o,
    output logic [DATA_WIDTH-1:0] comp_a_o,
    output logic [DATA_WIDTH-1:0] comp_b_o,
    input  logic                  comp_ready_i,
    input  logic                  comp_valid_i,
    input  logic [DATA_WIDTH-1:0] comp_result_i,
    input  logic                  comp_flag_i,
    output logic                  comp_ready_o,
    output logic                  wb_valid_o,
    output logic [VID_WIDTH-1:0]  wb_vid_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic                  wb_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RSP, S_ISSUE, S_RES, S_WB, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [VID_WIDTH-1:0]  n_q, n_d;
    logic [VID_WIDTH-1:0]  vid_q, vid_d;
    logic [VID_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dst_q, dst_d;
    logic [DATA_WIDTH-1:0] tmp_q, tmp_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  conv_q, conv_d;
    logic                  last_vid;

    // Only evaluated once a pass is running, where n >= 1, so n-1 never wraps.
    assign last_vid = (vid_q == n_q - VID_WIDTH'(1));

    // NOTE: every state register uses non-blocking assignment and is cleared by
    // the async reset, so a reset mid-pass leaves no stale operands behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            vid_q   <= '0;
            cnt_q   <= '0;
            dst_q   <= '0;
            tmp_q   <= '0;
            res_q   <= '0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            vid_q   <= vid_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            tmp_q   <= tmp_d;
            res_q   <= res_d;
            conv_q  <= conv_d;
        end
    end

    // NOTE: all next-state signals get a hold default first so no latches form.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        vid_d   = vid_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        tmp_d   = tmp_q;
        res_d   = res_q;
        conv_d  = conv_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = num_vertices;
                    vid_d   = '0;
                    cnt_d   = '0;
                    conv_d  = 1'b0;
                    state_d = (num_vertices == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (rd_ready_i) state_d = S_RSP;
            end
            S_RSP: begin
                if (rd_rsp_valid_i) begin
                    dst_d   = rd_dst_i;
                    tmp_d   = rd_tmp_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (comp_ready_i) state_d = S_RES;
            end
            S_RES: begin
                if (comp_valid_i) begin
                    if (comp_flag_i) begin
                        res_d   = comp_result_i;
                        state_d = S_WB;
                    end else if (last_vid) begin
                        state_d = S_DONE;
                    end else begin
                        vid_d   = vid_q + VID_WIDTH'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_WB: begin
                if (wb_ready_i) begin
                    cnt_d = cnt_q + VID_WIDTH'(1);
                    if (last_vid) begin
                        state_d = S_DONE;
                    end else begin
                        vid_d   = vid_q + VID_WIDTH'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Use the next count so a final writeback is reflected in the done cycle.
        if (state_d == S_DONE && state_q != S_DONE) conv_d = (cnt_d == '0);
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign rd_valid_o     = (state_q == S_REQ);
    assign rd_rsp_ready_o = (state_q == S_RSP);
    assign comp_valid_o   = (state_q == S_ISSUE);
    assign comp_ready_o   = (state_q == S_RES);
    assign wb_valid_o     = (state_q == S_WB);
    assign rd_vid_o       = vid_q;
    assign wb_vid_o       = vid_q;
    assign comp_a_o       = dst_q;
    assign comp_b_o       = tmp_q;
    assign wb_data_o      = res_q;
    assign update_count   = cnt_q;
    assign converged      = conv_q;

endmodule

// File: tb/tb_apply_ctrl.sv
// Scoreboard bench for apply_ctrl: models vertex store, comp and writeback sink;
// expected reads/operands/writebacks are queued at pass start and popped on transfer.
module tb_apply_ctrl;
    localparam int DW = 64;
    localparam int VW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [VW-1:0] num_vertices;
    logic          busy, done, converged;
    logic [VW-1:0] update_count;
    logic          rd_valid_o, rd_ready_i, rd_rsp_valid_i, rd_rsp_ready_o;
    logic [VW-1:0] rd_vid_o;
    logic [DW-1:0] rd_dst_i, rd_tmp_i;
    logic          comp_valid_o, comp_ready_i, comp_valid_i, comp_flag_i, comp_ready_o;
    logic [DW-1:0] comp_a_o, comp_b_o, comp_result_i;
    logic          wb_valid_o, wb_ready_i;
    logic [VW-1:0] wb_vid_o;
    logic [DW-1:0] wb_data_o;

    always #5 clk = ~clk;

    apply_ctrl #(.DATA_WIDTH(DW), .VID_WIDTH(VW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vertices(num_vertices),
        .busy(busy), .done(done), .update_count(update_count), .converged(converged),
        .rd_valid_o(rd_valid_o), .rd_vid_o(rd_vid_o), .rd_ready_i(rd_ready_i),
        .rd_rsp_valid_i(rd_rsp_valid_i), .rd_dst_i(rd_dst_i), .rd_tmp_i(rd_tmp_i),
        .rd_rsp_ready_o(rd_rsp_ready_o),
        .comp_valid_o(comp_valid_o), .comp_a_o(comp_a_o), .comp_b_o(comp_b_o),
        .comp_ready_i(comp_ready_i), .comp_valid_i(comp_valid_i),
        .comp_result_i(comp_result_i), .comp_flag_i(comp_flag_i), .comp_ready_o(comp_ready_o),
        .wb_valid_o(wb_valid_o), .wb_vid_o(wb_vid_o), .wb_data_o(wb_data_o),
        .wb_ready_i(wb_ready_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard queues and the bench's own vertex store.
    logic [VW-1:0] exp_rd_q[$];
    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    logic [VW-1:0] exp_wbv_q[$];
    logic [DW-1:0] exp_wbd_q[$];
    logic [DW-1:0] mem_dst[16];
    logic [DW-1:0] mem_tmp[16];

    int            stall_cfg = 0;
    int            rd_stall = 0, comp_stall = 0, wb_stall = 0;
    int            done_cnt = 0, rd_cnt = 0, base_done = 0, base_rd = 0, cur_n = 0;
    logic          rd_pend = 1'b0, comp_pend = 1'b0, comp_pend_flag = 1'b0;
    logic [VW-1:0] rd_pend_vid = '0;
    logic [DW-1:0] comp_pend_res = '0;
    logic [VW-1:0] exp_cnt_cur = '0;
    logic          exp_conv_cur = 1'b0;

    // Responders: act on negedge, so readies/valids set here are seen at the next posedge.
    initial begin
        rd_ready_i = 0; rd_rsp_valid_i = 0; rd_dst_i = '0; rd_tmp_i = '0;
        comp_ready_i = 0; comp_valid_i = 0; comp_result_i = '0; comp_flag_i = 0;
        wb_ready_i = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rd_ready_i = 0; rd_rsp_valid_i = 0; comp_ready_i = 0;
                comp_valid_i = 0; wb_ready_i = 0;
                rd_pend = 0; comp_pend = 0;
                rd_stall = 0; comp_stall = 0; wb_stall = 0;
                continue;
            end
            if (done) begin
                done_cnt++;
                check("count_at_done", update_count, exp_cnt_cur);
                check("conv_at_done", converged, exp_conv_cur);
            end
            // Read response, presented only when the DUT is ready for it.
            if (rd_pend && rd_rsp_ready_o) begin
                rd_rsp_valid_i = 1; rd_dst_i = mem_dst[rd_pend_vid[3:0]];
                rd_tmp_i = mem_tmp[rd_pend_vid[3:0]]; rd_pend = 0;
            end else begin
                rd_rsp_valid_i = 0; rd_dst_i = {$urandom, $urandom}; rd_tmp_i = {$urandom, $urandom};
            end
            rd_ready_i = 0;
            if (rd_valid_o) begin
                if (exp_rd_q.size() == 0) check("rd_extra", rd_valid_o, 0);
                else begin
                    check("rd_vid", rd_vid_o, exp_rd_q[0]);
                    if (rd_stall > 0) rd_stall--;
                    else begin
                        rd_ready_i = 1; rd_pend = 1; rd_pend_vid = exp_rd_q.pop_front();
                        rd_cnt++; rd_stall = stall_cfg;
                    end
                end
            end
            // Comp model: flag when operands differ, result = a ^ b, one-cycle latency.
            if (comp_pend && comp_ready_o) begin
                comp_valid_i = 1; comp_result_i = comp_pend_res;
                comp_flag_i = comp_pend_flag; comp_pend = 0;
            end else begin
                comp_valid_i = 0; comp_result_i = {$urandom, $urandom}; comp_flag_i = 1'($urandom);
            end
            comp_ready_i = 0;
            if (comp_valid_o) begin
                if (exp_a_q.size() == 0) check("comp_extra", comp_valid_o, 0);
                else begin
                    check("comp_a", comp_a_o, exp_a_q[0]);
                    check("comp_b", comp_b_o, exp_b_q[0]);
                    if (comp_stall > 0) comp_stall--;
                    else begin
                        comp_ready_i = 1; comp_pend = 1;
                        comp_pend_flag = (exp_a_q[0] != exp_b_q[0]);
                        comp_pend_res = exp_a_q.pop_front() ^ exp_b_q.pop_front();
                        comp_stall = stall_cfg;
                    end
                end
            end
            wb_ready_i = 0;
            if (wb_valid_o) begin
                if (exp_wbv_q.size() == 0) check("wb_extra", wb_valid_o, 0);
                else begin
                    check("wb_vid", wb_vid_o, exp_wbv_q[0]);
                    check("wb_data", wb_data_o, exp_wbd_q[0]);
                    if (wb_stall > 0) wb_stall--;
                    else begin
                        wb_ready_i = 1;
                        void'(exp_wbv_q.pop_front()); void'(exp_wbd_q.pop_front());
                        wb_stall = stall_cfg;
                    end
                end
            end
        end
    end

    task automatic clear_sb();
        exp_rd_q.delete(); exp_a_q.delete(); exp_b_q.delete();
        exp_wbv_q.delete(); exp_wbd_q.delete();
    endtask

    task automatic launch(input int n);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            exp_rd_q.push_back(VW'(i));
            exp_a_q.push_back(mem_dst[i]);
            exp_b_q.push_back(mem_tmp[i]);
            if (mem_dst[i] != mem_tmp[i]) begin
                exp_wbv_q.push_back(VW'(i));
                exp_wbd_q.push_back(mem_dst[i] ^ mem_tmp[i]);
                cnt++;
            end
        end
        exp_cnt_cur = VW'(cnt);
        exp_conv_cur = (cnt == 0);
        rd_stall = stall_cfg; comp_stall = stall_cfg; wb_stall = stall_cfg;
        base_done = done_cnt; base_rd = rd_cnt; cur_n = n;
        start = 1; num_vertices = VW'(n);
        @(negedge clk);
        start = 0; num_vertices = $urandom;
        if (n == 0) check("zero_done_lat", done, 1);
        else begin
            check("start_busy", busy, 1);
            check("first_rd_lat", rd_valid_o, 1);
            check("count_cleared", update_count, 0);
        end
    endtask

    task automatic finish_pass();
        for (int k = 0; k < 3000 && done_cnt == base_done; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt, base_done + 1);
        check("reads", rd_cnt, base_rd + cur_n);
        check("count_end", update_count, exp_cnt_cur);
        check("conv_end", converged, exp_conv_cur);
        check("busy_end", busy, 0);
        check("sb_left", exp_rd_q.size() + exp_a_q.size() + exp_wbv_q.size(), 0);
        clear_sb();
    endtask

    initial begin
        rst = 0; start = 0; num_vertices = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_conv", converged, 0);
        check("rst_count", update_count, 0);
        check("rst_valids", {rd_valid_o, rd_rsp_ready_o, comp_valid_o, comp_ready_o, wb_valid_o}, 0);
        check("rst_data", rd_vid_o | wb_vid_o | wb_data_o | comp_a_o | comp_b_o, 0);
        rst = 1;
        @(negedge clk);

        // Zero vertices.
        launch(0);
        finish_pass();

        // No updates.
        for (int i = 0; i < 4; i++) begin
            mem_dst[i] = 64'h100 + 64'(i); mem_tmp[i] = 64'h100 + 64'(i);
        end
        launch(4);
        finish_pass();

        // All updates.
        for (int i = 0; i < 3; i++) begin
            mem_dst[i] = 64'h10 + 64'(i); mem_tmp[i] = '0;
        end
        launch(3);
        finish_pass();

        // Mixed flags, first without then with backpressure.
        mem_dst[0] = 64'h5; mem_tmp[0] = 64'h5;
        mem_dst[1] = 64'h7; mem_tmp[1] = 64'h3;
        stall_cfg = 0;
        launch(2);
        finish_pass();
        stall_cfg = 3;
        launch(2);
        finish_pass();
        stall_cfg = 0;

        // start while busy must be ignored.
        launch(2);
        @(negedge clk);
        start = 1; num_vertices = 9;
        @(negedge clk);
        start = 0;
        finish_pass();

        // Reset while parked in WB.
        for (int i = 0; i < 3; i++) begin
            mem_dst[i] = 64'h10 + 64'(i); mem_tmp[i] = '0;
        end
        launch(3);
        wb_stall = 100000;
        for (int k = 0; k < 200 && !wb_valid_o; k++) @(negedge clk);
        check("wb_reached", wb_valid_o, 1);
        base_done = done_cnt;
        @(posedge clk);
        #2 rst = 0;
        #1;
        check("arst_wb_valid", wb_valid_o, 0);
        check("arst_busy", busy, 0);
        check("arst_valids", {rd_valid_o, rd_rsp_ready_o, comp_valid_o, comp_ready_o}, 0);
        check("arst_count", update_count, 0);
        clear_sb();
        @(posedge clk);
        #2 rst = 1;
        @(negedge clk);
        check("arst_no_done", done_cnt, base_done);
        mem_dst[0] = 64'h5; mem_tmp[0] = 64'h5;
        mem_dst[1] = 64'h7; mem_tmp[1] = 64'h3;
        launch(2);
        finish_pass();

        // Random data with light backpressure.
        for (int i = 0; i < 10; i++) begin
            mem_dst[i] = {$urandom, $urandom};
            mem_tmp[i] = ($urandom_range(0, 1) == 1) ? mem_dst[i] : {$urandom, $urandom};
        end
        stall_cfg = 1;
        launch(10);
        finish_pass();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
